fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_pc_reg.sv | 36 +++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding and the canonical NOP (addi x0,x0,0).
package fetch_stage_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: load wins over hold, otherwise advance by 4 (wraps mod 2^PC_W).
// Single-cycle update; a held PC is the only backpressure mechanism.
module pc_reg #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            hold,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (!hold) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC sequencing, IF/ID register, RUN/HALTED FSM; redirect visible on PC next cycle.
// Stall holds PC and IF/ID; redirect overrides stall; optional counters under FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Halt_com,
  input  logic [31:0]     Instr_mem,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Halted,
  output logic            Misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     Cycle_Cnt,
  output logic [31:0]     Fetch_Cnt
`endif
);

  fetch_state_e    state_d, state_q;
  logic [PC_W-1:0] ifid_pc_d, ifid_pc_q;
  logic [31:0]     ifid_instr_d, ifid_instr_q;
  logic            ifid_valid_d, ifid_valid_q;
  logic            halted_d, halted_q;
  logic            misalign_d, misalign_q;

  logic            in_run;
  logic            redirect;
  logic            bad_target;
  logic            stop_req;
  logic            take_br;
  logic            advance;
  logic [PC_W-1:0] pc_cur;

  // Bits of BrPC above the PC width are intentionally dropped.
  logic            unused_br_hi;
  assign unused_br_hi = ^BrPC[31:PC_W];

  assign in_run     = (state_q == RUN);
  assign redirect   = in_run && PcSel;
  assign bad_target = is_misaligned(BrPC[1:0]);
  assign stop_req   = redirect && (Halt_com || bad_target);
  assign take_br    = redirect && !stop_req;
  assign advance    = in_run && !PcSel && !Stall;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (take_br),
    .hold    (!take_br && !advance),
    .load_pc (BrPC[PC_W-1:0]),
    .pc      (pc_cur)
  );

  always_comb begin
    state_d      = state_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    misalign_d   = misalign_q;
    if (redirect) begin
      // Any redirect (taken, halt or bad target) squashes the slot being fetched.
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      if (stop_req) begin
        state_d  = HALTED;
        halted_d = 1'b1;
        if (!Halt_com) begin
          misalign_d = 1'b1;
        end
      end
    end else if (advance) begin
      ifid_pc_d    = pc_cur;
      ifid_instr_d = Instr_mem;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      misalign_q   <= misalign_d;
    end
  end

  assign PC         = pc_cur;
  assign IfId_PC    = ifid_pc_q;
  assign IfId_Instr = ifid_instr_q;
  assign IfId_Valid = ifid_valid_q;
  assign Halted     = halted_q;
  assign Misalign   = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt_d, cycle_cnt_q;
  logic [31:0] fetch_cnt_d, fetch_cnt_q;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (in_run) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (advance) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign Cycle_Cnt = cycle_cnt_q;
  assign Fetch_Cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free run, stall, redirect, halt, misalign, PC wrap.
module tb_fetch_stage;

  localparam int PC_W = 9;

  logic            clk;
  logic            reset;
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Halt_com;
  logic [31:0]     Instr_mem;
  logic [PC_W-1:0] PC;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Instr;
  logic            IfId_Valid;
  logic            Halted;
  logic            Misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     Cycle_Cnt;
  logic [31:0]     Fetch_Cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fetch_stage #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .Halt_com   (Halt_com),
    .Instr_mem  (Instr_mem),
    .PC         (PC),
    .IfId_PC    (IfId_PC),
    .IfId_Instr (IfId_Instr),
    .IfId_Valid (IfId_Valid),
    .Halted     (Halted),
    .Misalign   (Misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Cycle_Cnt  (Cycle_Cnt),
    .Fetch_Cnt  (Fetch_Cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: three known words, then an address-tagged pattern.
  always_comb begin
    case (PC)
      9'h000:  Instr_mem = 32'h00000011;
      9'h004:  Instr_mem = 32'h00000022;
      9'h008:  Instr_mem = 32'h00000033;
      default: Instr_mem = 32'h10000000 | 32'(PC);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sel, input logic [31:0] br, input logic hc);
    Stall    = st;
    PcSel    = sel;
    BrPC     = br;
    Halt_com = hc;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc_e, input logic [31:0] ins_e,
                            input logic v_e);
    check({tag, ".ifid_pc"}, 32'(IfId_PC), pc_e);
    check({tag, ".ifid_instr"}, IfId_Instr, ins_e);
    check({tag, ".ifid_valid"}, 32'(IfId_Valid), 32'(v_e));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    check("rst.pc", 32'(PC), 32'h0);
    check_ifid("rst", 32'h0, 32'h13, 1'b0);
    check("rst.halted", 32'(Halted), 32'h0);
    check("rst.misalign", 32'(Misalign), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst.cycle_cnt", Cycle_Cnt, 32'h0);
    check("rst.fetch_cnt", Fetch_Cnt, 32'h0);
`endif

    // Free run
    reset = 1'b0;
    step();
    check("run1.pc", 32'(PC), 32'h4);
    check_ifid("run1", 32'h0, 32'h11, 1'b1);
    step();
    check("run2.pc", 32'(PC), 32'h8);
    check_ifid("run2", 32'h4, 32'h22, 1'b1);

    // Stall two cycles at PC=8
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall.pc", 32'(PC), 32'h8);
      check_ifid("stall", 32'h4, 32'h22, 1'b1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check("run3.pc", 32'(PC), 32'hC);
    check_ifid("run3", 32'h8, 32'h33, 1'b1);

    // Redirect wins over stall
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    step();
    check("br.pc", 32'(PC), 32'h40);
    check("br.ifid_instr", IfId_Instr, 32'h13);
    check("br.ifid_valid", 32'(IfId_Valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check("br2.pc", 32'(PC), 32'h44);
    check_ifid("br2", 32'h40, 32'h10000040, 1'b1);

    // Halt_com without PcSel is ignored
    drive(1'b0, 1'b1, 32'h1C, 1'b0);
    step();
    check("br1c.pc", 32'(PC), 32'h1C);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    check("hcign.pc", 32'(PC), 32'h20);
    check("hcign.halted", 32'(Halted), 32'h0);
    check_ifid("hcign", 32'h1C, 32'h1000001C, 1'b1);

    // Committed halt at PC=0x20
    drive(1'b0, 1'b1, 32'h80, 1'b1);
    step();
    check("halt.pc", 32'(PC), 32'h20);
    check("halt.halted", 32'(Halted), 32'h1);
    check("halt.misalign", 32'(Misalign), 32'h0);
    check("halt.ifid_instr", IfId_Instr, 32'h13);
    check("halt.ifid_valid", 32'(IfId_Valid), 32'h0);
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 1'b1, 32'h80 + 32'(i * 4), i[1]);
      step();
      check("halted.pc", 32'(PC), 32'h20);
      check("halted.halted", 32'(Halted), 32'h1);
      check("halted.valid", 32'(IfId_Valid), 32'h0);
    end

    // Reset exits HALTED even with a redirect pending
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    step();
    check("rst2.pc", 32'(PC), 32'h0);
    check("rst2.halted", 32'(Halted), 32'h0);
    check_ifid("rst2", 32'h0, 32'h13, 1'b0);
    reset = 1'b0;

    // Misaligned target
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check("mis0.pc", 32'(PC), 32'h4);
    drive(1'b0, 1'b1, 32'h42, 1'b0);
    step();
    check("mis.pc", 32'(PC), 32'h4);
    check("mis.halted", 32'(Halted), 32'h1);
    check("mis.misalign", 32'(Misalign), 32'h1);
    check("mis.ifid_valid", 32'(IfId_Valid), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mishold.pc", 32'(PC), 32'h4);
      check("mishold.misalign", 32'(Misalign), 32'h1);
`ifdef FETCH_PERF_CNT_EN
      check("mishold.cycle_cnt", Cycle_Cnt, 32'd2);
      check("mishold.fetch_cnt", Fetch_Cnt, 32'd1);
`endif
    end

    // Wrap at top of PC space; upper BrPC bits dropped
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    step();
    check("wrap.pc0", 32'(PC), 32'h1F8);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    check("wrap.pc1", 32'(PC), 32'h1FC);
    check_ifid("wrap1", 32'h1F8, 32'h100001F8, 1'b1);
    step();
    check("wrap.pc2", 32'(PC), 32'h000);
    check("wrap.halted", 32'(Halted), 32'h0);
    check_ifid("wrap2", 32'h1FC, 32'h100001FC, 1'b1);
    step();
    check("wrap.pc3", 32'(PC), 32'h004);
    check_ifid("wrap3", 32'h000, 32'h11, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
